// File: rtl/sequence_mul.sv
// sequence_mul: unsigned 8x8 shift-and-add multiplier, one product per assertion of en.
// Latency: start sampled at edge N, z/z_flag update at edge N+8, z_flag drops at edge N+9.
// Backpressure: none; en is level-sensitive and must fall (HOLD->IDLE) before a new start.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   en     - start request, sampled while IDLE
//   a, b   - 8-bit unsigned operands, captured on the start edge only
//   z      - 16-bit product register, holds the last completed result
//   z_flag - one-cycle result-valid strobe
module sequence_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] z,
  output logic        z_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [2:0]  cnt;
  logic [15:0] acc_sum;
  logic        last_iter;

  // Partial-product add for the current iteration; on the final iteration this
  // sum is the complete product and goes straight into z.
  assign acc_sum   = acc + (mplier[0] ? mcand : 16'h0000);
  assign last_iter = (state == BUSY) && (cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = BUSY;
      BUSY: if (cnt == 3'd7) state_nxt = en ? HOLD : IDLE;
      HOLD: if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= 16'h0000;
      mplier <= 8'h00;
      acc    <= 16'h0000;
      cnt    <= 3'd0;
      z      <= 16'h0000;
      z_flag <= 1'b0;
    end else begin
      z_flag <= last_iter;
      if (state == IDLE && en) begin
        mcand  <= {8'h00, a};
        mplier <= b;
        acc    <= 16'h0000;
        cnt    <= 3'd0;
      end else if (state == BUSY) begin
        acc    <= acc_sum;
        mcand  <= {mcand[14:0], 1'b0};
        mplier <= {1'b0, mplier[7:1]};
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          z <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sequence_mul.sv
// Directed bench for sequence_mul: reset, basic product, re-trigger, corners,
// operand/enable changes after start, and reset in the middle of an operation.
module tb_sequence_mul;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] z;
  logic        z_flag;

  int compared = 0;
  int mismatched = 0;

  sequence_mul dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .b      (b),
    .z      (z),
    .z_flag (z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an operation at the next posedge (edge N) and watch edges N..N+15.
  // en stays high for en_cycles sampled edges; chg scrambles a/b right after start.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] prod, input logic [15:0] old_z,
                        input int en_cycles, input bit chg);
    a  = va;
    b  = vb;
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("%s.flag.k%0d", tag, k), {15'd0, z_flag}, (k == 8) ? 16'h0001 : 16'h0000);
      check($sformatf("%s.z.k%0d", tag, k), z, (k >= 8) ? prod : old_z);
      if (k + 1 >= en_cycles) en = 1'b0;
      if (chg && k == 0) begin
        a = ~va;
        b = vb ^ 8'h5A;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    a = 8'h00;
    b = 8'h00;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a  = 8'($urandom);
      b  = 8'($urandom);
      en = 1'($urandom);
      check("rst.z", z, 16'h0000);
      check("rst.flag", {15'd0, z_flag}, 16'h0000);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle.z", z, 16'h0000);
      check("idle.flag", {15'd0, z_flag}, 16'h0000);
    end

    // Basic product with en held high; no second pulse while held.
    run_op("basic", 8'hAF, 8'h34, 16'h238C, 16'h0000, 15, 1'b0);

    // en low for 10 cycles, z must hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gap.z", z, 16'h238C);
      check("gap.flag", {15'd0, z_flag}, 16'h0000);
    end

    run_op("retrig", 8'h5E, 8'h4C, 16'h1BE8, 16'h238C, 3, 1'b0);

    // Corners.
    run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01, 16'h1BE8, 1, 1'b0);
    run_op("00xa5", 8'h00, 8'hA5, 16'h0000, 16'hFE01, 1, 1'b0);
    run_op("01x80", 8'h01, 8'h80, 16'h0080, 16'h0000, 1, 1'b0);
    run_op("80xff", 8'h80, 8'hFF, 16'h7F80, 16'h0080, 1, 1'b0);

    // Operands change and en drops one cycle after start.
    run_op("chg", 8'h9C, 8'h2B, 16'h1A34, 16'h7F80, 1, 1'b1);

    // Reset in the middle of an operation.
    a  = 8'h12;
    b  = 8'h34;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.z", z, 16'h0000);
    check("midrst.flag", {15'd0, z_flag}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst.z", z, 16'h0000);
      check("postrst.flag", {15'd0, z_flag}, 16'h0000);
    end
    run_op("afterrst", 8'h12, 8'h34, 16'h03A8, 16'h0000, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
